// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph
// table, the all-dark code and segment bit positions within dispcode.
// Optional feature macro used by the top: SEG_LZ_SUPPRESS_EN.
package seg_pkg;

    // All segments and the decimal point dark (active-low outputs).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Bit positions inside dispcode = {dp, g, f, e, d, c, b, a}.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-low glyphs with the decimal point dark.
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    // Entry [n] holds the glyph for nibble n.
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
        GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
        GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment code.
// A single instance is shared by all digits through the scan mux.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    // Table lookup; the decimal point bit is handled by the scanner.
    always_comb begin
        segs = GLYPH_TABLE[nibble][6:0];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. Latches a packed
// hex word with per-digit decimal-point and blank masks, scans one digit
// per SCAN_DIV-cycle slot with a one-cycle dark gap at the start of each
// slot, and drives registered active-low anodes and segment codes.
// Optional feature: define SEG_LZ_SUPPRESS_EN for leading-zero blanking.
//
// Capture strobe: load is a single-cycle qualifier with no back-pressure;
// on every rising edge with load=1 and reset=0 the shadow registers take
// data_in/dp_in/blank_in. Reset has priority over load.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              dispcode,
    output logic                    frame_tick
);

    localparam int PCNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [4*N_DIGITS-1:0] data_q;
    logic [N_DIGITS-1:0]   dp_q;
    logic [N_DIGITS-1:0]   blank_q;

    logic [PCNT_W-1:0]     pcnt;
    logic [IDX_W-1:0]      idx;

    logic [N_DIGITS-1:0]   lz_mask;

    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blank_sel;
    logic                  lz_sel;
    logic [N_DIGITS-1:0]   an_sel;
    logic [6:0]            glyph_segs;

    logic [N_DIGITS-1:0]   an_next;
    logic [7:0]            disp_next;
    logic                  slot_end;
    logic                  frame_end;

    assign slot_end  = (pcnt == PCNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Shadow registers: the display only ever reads these.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (load) begin
            data_q  <= data_in;
            dp_q    <= dp_in;
            blank_q <= blank_in;
        end
    end

    // Slot prescaler and digit index; index steps on the last slot cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            if (slot_end) begin
                pcnt <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic still_leading;

    // Leading-zero mask: walk down from the top digit while nibbles are
    // zero with no decimal point; digit 0 is always shown.
    always_comb begin
        lz_mask       = '0;
        still_leading = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (still_leading && (data_q[4*k +: 4] == 4'h0) && !dp_q[k]) begin
                lz_mask[k] = 1'b1;
            end else begin
                still_leading = 1'b0;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Select the active digit's shadow fields and its anode pattern.
    always_comb begin
        nib_sel   = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        lz_sel    = 1'b0;
        an_sel    = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nib_sel   = data_q[4*k +: 4];
                dp_sel    = dp_q[k];
                blank_sel = blank_q[k];
                lz_sel    = lz_mask[k];
                an_sel[k] = 1'b0;
            end
        end
    end

    seg_glyph_rom u_glyph_rom (
        .nibble (nib_sel),
        .segs   (glyph_segs)
    );

    // Next output values: dark gap on the slot's first cycle, else glyph.
    always_comb begin
        an_next   = (pcnt == '0) ? '1 : an_sel;
        disp_next = SEG_OFF;
        if ((pcnt != '0) && !blank_sel && !lz_sel) begin
            disp_next         = {1'b1, glyph_segs};
            disp_next[SEG_DP] = ~dp_sel;
        end
    end

    // Registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= '1;
            dispcode   <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            dispcode   <= disp_next;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. Latches a packed hex word plus per-digit decimal-point and blank masks, scans one digit at a time at a parametrised rate, and drives active-low anode selects and active-low segment codes. Sits between the CPU debug/status datapath and the board display pins, replacing a per-digit combinational hex decoder with a single shared decoder and scan sequencer.

## Interface
- N_DIGITS, 4: number of digits scanned; legal 1..8.
- SCAN_DIV, 100000: clock cycles per digit slot; legal ≥2.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture strobe for data_in/dp_in/blank_in.
- data_in  input  4*N_DIGITS  packed hex nibbles; digit k = data_in[4k+3:4k], digit 0 rightmost.
- dp_in  input  N_DIGITS  decimal point enable per digit, 1 = lit.
- blank_in  input  N_DIGITS  force digit dark, 1 = blank.
- an  output  N_DIGITS  anode selects, active-low, registered.
- dispcode  output  8  {dp, g, f, e, d, c, b, a}, active-low, registered.
- frame_tick  output  1  one-cycle pulse when scan wraps from digit N_DIGITS-1 to 0.

## Operation
- Shadow registers data_q, dp_q, blank_q capture inputs on any edge with load=1; display uses only shadow values. No load → shadow holds indefinitely.
- Prescaler pcnt counts 0..SCAN_DIV-1, wraps to 0. Width $clog2(SCAN_DIV).
- Digit index idx advances when pcnt = SCAN_DIV-1; wraps N_DIGITS-1 → 0. frame_tick asserts on the edge where idx wraps to 0.
- Ghost gap: in the slot's first cycle (pcnt=0), an = all ones, dispcode = 8'hFF. Remaining SCAN_DIV-1 cycles: an = ~(1<<idx), dispcode = decoded glyph.
- Glyph: hex nibble → segments with standard table (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E); bit 7 cleared when dp_q[idx]=1.
- blank_q[idx]=1 → dispcode = 8'hFF (dp also dark); anode still asserted.
- Reset values: an all ones, dispcode 8'hFF, frame_tick 0, pcnt 0, idx 0, data_q/dp_q/blank_q all 0.

## Timing
- Outputs registered: an/dispcode reflect pcnt/idx/shadow state of the previous cycle (latency 1).
- load at edge t → new value visible on dispcode from edge t+1 if digit currently active; no tearing within one cycle.
- load while reset high: reset wins, shadow cleared.
- Reset asserted mid-slot: outputs go to reset values at next edge; scan restarts at digit 0, pcnt 0.
- N_DIGITS=1: idx constant 0, frame_tick pulses every SCAN_DIV cycles.
- Slot period SCAN_DIV cycles; frame period N_DIGITS*SCAN_DIV cycles.

## Configuration
- SEG_LZ_SUPPRESS_EN defined: leading-zero suppression. Starting from digit N_DIGITS-1 downward, digits with nibble 0 and dp_q=0 are blanked until the first nonzero nibble or set dp; digit 0 never suppressed.
- Undefined: all digits shown as decoded; only blank_q blanks. Suppression logic absent.

## Structure
- Package seg_pkg: 16-entry glyph constants, SEG_OFF = 8'hFF, segment bit-position localparams.
- Sub-module seg_glyph_rom: combinational 4-bit nibble → 7-bit segment code, one instance shared by the scanner.
- Top holds prescaler, idx, shadow registers, suppression mask, output registers.

## Test plan
- Reset: hold reset 5 cycles → an=4'b1111, dispcode=8'hFF, frame_tick=0 throughout; release, load data_in=16'h1234 → with SCAN_DIV=4 digit 0 slot shows gap cycle then an=4'b1110, dispcode=8'h99 for 3 cycles.
- Scan order: continue → an sequence 1110, 1101, 1011, 0111 with codes B0, A4, F9; frame_tick single pulse every 16 cycles on wrap to digit 0.
- DP/blank: data_in=16'h8888, dp_in=4'b0010, blank_in=4'b0100 → digit1 dispcode=8'h00, digit2 8'hFF, digits 0/3 8'h80.
- Load mid-slot: during digit0 active, load data_in=16'h000F → next cycle dispcode=8'h8E; no change without load when data_in toggles.
- Suppression: data_in=16'h0050 → with SEG_LZ_SUPPRESS_EN digits 3,2 = 8'hFF, digit1 = 8'h92, digit0 = 8'hC0; without macro digits 3,2 = 8'hC0.
- Reset mid-frame: assert reset during digit 2 → next edge outputs at reset values; after release scan resumes at digit 0 with shadow cleared (dispcode 8'hC0).
